// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display blocks: scan states,
// active-low pin polarities and the hex-to-segment table.
package seg7_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    GUARD = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // Display pins are active-low: 0 lights a segment or selects an anode.
  localparam logic       SEG_ON    = 1'b0;
  localparam logic       SEG_OFF   = 1'b1;
  localparam logic       ANODE_ON  = 1'b0;
  localparam logic       ANODE_OFF = 1'b1;
  localparam logic [6:0] SEGS_DARK = 7'b1111111;

  // Segment patterns a..g (a in the MSB), active-low, indexed by nibble.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the datapath (master) and the scan driver (slave).
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    ENABLE;
  logic                    LOAD;
  logic [4*NUM_DIGITS-1:0] VALUE;
  logic [NUM_DIGITS-1:0]   DP_MASK;
  logic [NUM_DIGITS-1:0]   BLANK_MASK;
  logic [NUM_DIGITS+7:0]   DISP;
  logic                    FRAME;

  modport master (
    output ENABLE, LOAD, VALUE, DP_MASK, BLANK_MASK,
    input  DISP, FRAME
  );

  modport slave (
    input  ENABLE, LOAD, VALUE, DP_MASK, BLANK_MASK,
    output DISP, FRAME
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low a..g segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner. Each digit slot
// begins with a guard interval (all anodes off) to avoid ghosting, then
// shows the digit. New data is latched into a shadow register on LOAD and
// only moves to the displayed (active) register at frame start.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 100000,
  parameter int GUARD_CYCLES = 100,
  parameter int LZ_SUPPRESS  = 0
) (
  input  logic                CLK,
  input  logic                RST_N,
  seg7_scan_driver_if.slave   bus
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic             LZ_EN      = (LZ_SUPPRESS != 0);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic                    frame_start;
  logic [NUM_DIGITS+7:0]   disp_reg, disp_next;
  logic                    frame_reg;

  logic [4*NUM_DIGITS-1:0] shadow_value_reg, active_value_reg;
  logic [NUM_DIGITS-1:0]   shadow_dp_reg, active_dp_reg;
  logic [NUM_DIGITS-1:0]   shadow_blank_reg, active_blank_reg;

  logic [3:0]              digit_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   digit_dp, digit_blank, lz_hide;
  logic [NUM_DIGITS-2:0]   lead_zero;
  logic [6:0]              cur_seg;

  // Per-digit views of the active register (digit 0 is the leftmost, held
  // in the top bits) plus the leading-zero chain running left to right.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_nib[gi]   = active_value_reg[4*(NUM_DIGITS-1-gi) +: 4];
    assign digit_dp[gi]    = active_dp_reg[NUM_DIGITS-1-gi];
    assign digit_blank[gi] = active_blank_reg[NUM_DIGITS-1-gi];
    if (gi == NUM_DIGITS - 1) begin : g_last
      // The rightmost digit always shows, so "0" is visible for a zero value.
      assign lz_hide[gi] = 1'b0;
    end else begin : g_chain
      if (gi == 0) begin : g_first
        assign lead_zero[gi] = (digit_nib[gi] == 4'h0);
      end else begin : g_rest
        assign lead_zero[gi] = lead_zero[gi-1] & (digit_nib[gi] == 4'h0);
      end
      assign lz_hide[gi] = LZ_EN & lead_zero[gi];
    end
  end

  seg7_hex_decode u_dec (
    .nib (digit_nib[idx_reg]),
    .seg (cur_seg)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_reg <= OFF;
    else        state_reg <= state_next;
  end

  // FSM next state: dropping ENABLE always forces OFF.
  always_comb begin
    state_next = state_reg;
    if (!bus.ENABLE) begin
      state_next = OFF;
    end else begin
      case (state_reg)
        OFF:     state_next = GUARD;
        GUARD:   if (cnt_reg == GUARD_LAST) state_next = SHOW;
        SHOW:    if (cnt_reg == SLOT_LAST)  state_next = GUARD;
        default: state_next = OFF;
      endcase
    end
  end

  // FSM outputs: slot counter, scan index, frame start and pin values.
  // The counter runs across the whole slot, guard included.
  always_comb begin
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    frame_start = 1'b0;
    disp_next   = '1;
    if (!bus.ENABLE) begin
      cnt_next = '0;
      idx_next = '0;
    end else begin
      case (state_reg)
        OFF: begin
          cnt_next    = '0;
          idx_next    = '0;
          frame_start = 1'b1;
        end
        GUARD: cnt_next = cnt_reg + 1'b1;
        SHOW: begin
          if (cnt_reg == SLOT_LAST) begin
            cnt_next = '0;
            if (idx_reg == IDX_LAST) begin
              idx_next    = '0;
              frame_start = 1'b1;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          cnt_next = '0;
          idx_next = '0;
        end
      endcase
      if (state_reg == SHOW) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (idx_reg == IDX_W'(i)) disp_next[8 + NUM_DIGITS - 1 - i] = ANODE_ON;
        end
        disp_next[7:1] = (digit_blank[idx_reg] || lz_hide[idx_reg]) ? SEGS_DARK : cur_seg;
        // A leading-zero-suppressed digit keeps its decimal point.
        disp_next[0]   = (!digit_blank[idx_reg] && digit_dp[idx_reg]) ? SEG_ON : SEG_OFF;
      end
    end
  end

  // Scan counters and registered display pins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_reg   <= '0;
      idx_reg   <= '0;
      disp_reg  <= {(NUM_DIGITS + 8){ANODE_OFF}};
      frame_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      disp_reg  <= disp_next;
      frame_reg <= frame_start;
    end
  end

  // Shadow captures on LOAD; active takes the pre-LOAD shadow at frame start.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow_value_reg <= '0;
      shadow_dp_reg    <= '0;
      shadow_blank_reg <= '0;
      active_value_reg <= '0;
      active_dp_reg    <= '0;
      active_blank_reg <= '0;
    end else begin
      if (bus.LOAD) begin
        shadow_value_reg <= bus.VALUE;
        shadow_dp_reg    <= bus.DP_MASK;
        shadow_blank_reg <= bus.BLANK_MASK;
      end
      if (frame_start) begin
        active_value_reg <= shadow_value_reg;
        active_dp_reg    <= shadow_dp_reg;
        active_blank_reg <= shadow_blank_reg;
      end
    end
  end

  assign bus.DISP  = disp_reg;
  assign bus.FRAME = frame_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: two instances, without and with
// leading-zero suppression, driven from one stimulus.
module tb_seg7_scan_driver;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blank_mask = '0;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus0 ();
  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus1 ();

  assign bus0.ENABLE     = enable;
  assign bus0.LOAD       = load;
  assign bus0.VALUE      = value;
  assign bus0.DP_MASK    = dp_mask;
  assign bus0.BLANK_MASK = blank_mask;
  assign bus1.ENABLE     = enable;
  assign bus1.LOAD       = load;
  assign bus1.VALUE      = value;
  assign bus1.DP_MASK    = dp_mask;
  assign bus1.BLANK_MASK = blank_mask;

  seg7_scan_driver #(.NUM_DIGITS(4), .DIGIT_CYCLES(8), .GUARD_CYCLES(2), .LZ_SUPPRESS(0)) dut0 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus0)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .DIGIT_CYCLES(8), .GUARD_CYCLES(2), .LZ_SUPPRESS(1)) dut1 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus1)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance one clock; LOAD is therefore always a single-cycle strobe.
  task automatic tick();
    @(posedge CLK);
    #1;
    load = 1'b0;
  endtask

  // Expected DISP for digit d lit with the given segments and dp pin.
  function automatic logic [11:0] dig(input int d, input logic [6:0] seg, input logic dp);
    logic [3:0] an;
    an = ~(4'b1000 >> d);
    return {an, seg, dp};
  endfunction

  task automatic wait_frame(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      tick();
      if (bus0.FRAME === 1'b1) seen = 1'b1;
    end
    check({tag, "_frame_seen"}, 32'(seen), 32'd1);
  endtask

  // Called in the cycle FRAME is high; walks the 32 cycles of one frame.
  // which: 0 = no-LZ instance, 1 = LZ instance, 2 = both.
  task automatic check_frame(input string tag, input int which,
                             input logic [11:0] e0, input logic [11:0] e1,
                             input logic [11:0] e2, input logic [11:0] e3);
    logic [11:0] exp_show [4];
    logic [11:0] ex;
    logic        fr;
    exp_show = '{e0, e1, e2, e3};
    for (int d = 0; d < 4; d++) begin
      for (int c = 1; c <= 8; c++) begin
        tick();
        ex = (c <= 2) ? 12'hFFF : exp_show[d];
        fr = (d == 3 && c == 8);
        if (which != 1) begin
          check($sformatf("%s_u0_d%0d_c%0d_disp", tag, d, c), 32'(bus0.DISP), 32'(ex));
          check($sformatf("%s_u0_d%0d_c%0d_frame", tag, d, c), 32'(bus0.FRAME), 32'(fr));
        end
        if (which != 0) begin
          check($sformatf("%s_u1_d%0d_c%0d_disp", tag, d, c), 32'(bus1.DISP), 32'(ex));
          check($sformatf("%s_u1_d%0d_c%0d_frame", tag, d, c), 32'(bus1.FRAME), 32'(fr));
        end
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_disp_u0", 32'(bus0.DISP), 32'h0000_0FFF);
    check("rst_frame_u0", 32'(bus0.FRAME), 32'd0);
    check("rst_disp_u1", 32'(bus1.DISP), 32'h0000_0FFF);
    check("rst_frame_u1", 32'(bus1.FRAME), 32'd0);
    RST_N = 1'b1;
    tick();
    tick();
    check("off_disp", 32'(bus0.DISP), 32'h0000_0FFF);
    check("off_frame", 32'(bus0.FRAME), 32'd0);

    // Basic hex scan of 12AF
    value = 16'h12AF; dp_mask = 4'b0000; blank_mask = 4'b0000; load = 1'b1;
    tick();
    enable = 1'b1;
    wait_frame("en");
    check_frame("f12af", 2, dig(0, 7'b1001111, 1'b1), dig(1, 7'b0010010, 1'b1),
                dig(2, 7'b0001000, 1'b1), dig(3, 7'b0111000, 1'b1));

    // LOAD in the FRAME cycle: old value held for this frame
    check("frame_at_load", 32'(bus0.FRAME), 32'd1);
    value = 16'h3456; load = 1'b1;
    check_frame("f_old", 2, dig(0, 7'b1001111, 1'b1), dig(1, 7'b0010010, 1'b1),
                dig(2, 7'b0001000, 1'b1), dig(3, 7'b0111000, 1'b1));
    check_frame("f3456", 2, dig(0, 7'b0000110, 1'b1), dig(1, 7'b1001100, 1'b1),
                dig(2, 7'b0100100, 1'b1), dig(3, 7'b0100000, 1'b1));

    // Leading-zero suppression; dp survives on a suppressed digit
    value = 16'h0700; dp_mask = 4'b1010; load = 1'b1;
    wait_frame("lz1");
    check_frame("lz0700", 1, dig(0, 7'b1111111, 1'b0), dig(1, 7'b0001111, 1'b1),
                dig(2, 7'b0000001, 1'b0), dig(3, 7'b0000001, 1'b1));
    value = 16'h0000; dp_mask = 4'b0000; load = 1'b1;
    wait_frame("lz2");
    check_frame("lz0000", 1, dig(0, 7'b1111111, 1'b1), dig(1, 7'b1111111, 1'b1),
                dig(2, 7'b1111111, 1'b1), dig(3, 7'b0000001, 1'b1));

    // Blank mask on digit 1
    value = 16'h8888; blank_mask = 4'b0100; load = 1'b1;
    wait_frame("blk");
    check_frame("blank", 2, dig(0, 7'b0000000, 1'b1), dig(1, 7'b1111111, 1'b1),
                dig(2, 7'b0000000, 1'b1), dig(3, 7'b0000000, 1'b1));

    // ENABLE drop in the middle of digit 2's SHOW phase
    repeat (20) tick();
    check("pre_drop", 32'(bus0.DISP), 32'(dig(2, 7'b0000000, 1'b1)));
    enable = 1'b0;
    tick();
    check("drop_disp", 32'(bus0.DISP), 32'h0000_0FFF);
    check("drop_frame", 32'(bus0.FRAME), 32'd0);
    repeat (3) tick();
    check("off_hold_disp", 32'(bus0.DISP), 32'h0000_0FFF);
    enable = 1'b1;
    tick();
    check("reen_frame", 32'(bus0.FRAME), 32'd1);
    check_frame("reen", 2, dig(0, 7'b0000000, 1'b1), dig(1, 7'b1111111, 1'b1),
                dig(2, 7'b0000000, 1'b1), dig(3, 7'b0000000, 1'b1));

    // Asynchronous reset between clock edges during digit 0's SHOW
    repeat (5) tick();
    check("pre_arst", 32'(bus0.DISP), 32'(dig(0, 7'b0000000, 1'b1)));
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_disp_u0", 32'(bus0.DISP), 32'h0000_0FFF);
    check("arst_disp_u1", 32'(bus1.DISP), 32'h0000_0FFF);
    check("arst_frame_u0", 32'(bus0.FRAME), 32'd0);
    tick();
    tick();
    check("arst_hold_disp", 32'(bus0.DISP), 32'h0000_0FFF);
    RST_N = 1'b1;
    tick();
    check("rel_frame", 32'(bus0.FRAME), 32'd1);
    check_frame("zero", 0, dig(0, 7'b0000001, 1'b1), dig(1, 7'b0000001, 1'b1),
                dig(2, 7'b0000001, 1'b1), dig(3, 7'b0000001, 1'b1));
    check_frame("zero_lz", 1, dig(0, 7'b1111111, 1'b1), dig(1, 7'b1111111, 1'b1),
                dig(2, 7'b1111111, 1'b1), dig(3, 7'b0000001, 1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
